// File: rtl/lsq_ram_pkg.sv
// Shared types and parameter helpers for the multi-port LSQ storage array.
// Partition geometry is derived from DEPTH and NUM_PARTS, so every instance computes it the same way.
package lsq_ram_pkg;

    localparam int DEPTH_DEF     = 32;
    localparam int NUM_PARTS_DEF = 4;
    localparam int PART_SIZE     = DEPTH_DEF / NUM_PARTS_DEF;
    localparam int PART_LOG      = $clog2(PART_SIZE);

    typedef enum logic {CLR_IDLE, CLR_BUSY} clr_state_t;

    function automatic int part_size(input int depth, input int parts);
        return depth / parts;
    endfunction

    function automatic int part_log(input int depth, input int parts);
        return $clog2(depth / parts);
    endfunction

    // At least two partitions and at least two entries per partition, so that
    // the partition-index and clear-pointer fields are each at least 1 bit wide.
    function automatic bit params_ok(input int depth, input int parts, input int index);
        return (depth > 1) && ((depth & (depth - 1)) == 0) &&
               (parts > 1) && ((parts & (parts - 1)) == 0) &&
               (depth % parts == 0) && (parts < depth) &&
               (index == $clog2(depth));
    endfunction

endpackage

// File: rtl/lsq_ram_mp_if.sv
// Port bundle for lsq_ram_mp: read/write address and data ports, partition power mask and ready flag.
interface lsq_ram_mp_if #(
    parameter int RD_PORTS  = 2,
    parameter int WR_PORTS  = 2,
    parameter int INDEX     = 5,
    parameter int WIDTH     = 8,
    parameter int NUM_PARTS = 4
);
    logic [NUM_PARTS-1:0]            partActive_i;
    logic [RD_PORTS-1:0][INDEX-1:0]  addr_i;
    logic [RD_PORTS-1:0][WIDTH-1:0]  data_o;
    logic [WR_PORTS-1:0][INDEX-1:0]  addrWr_i;
    logic [WR_PORTS-1:0][WIDTH-1:0]  dataWr_i;
    logic [WR_PORTS-1:0]             we_i;
    logic                            ramReady_o;

    modport master (
        output partActive_i, addr_i, addrWr_i, dataWr_i, we_i,
        input  data_o, ramReady_o
    );

    modport slave (
        input  partActive_i, addr_i, addrWr_i, dataWr_i, we_i,
        output data_o, ramReady_o
    );
endinterface

// File: rtl/lsq_ram_clear_seq.sv
// Clear sequencer: walks every pending partition entry by entry, lowest partition first,
// writing RESET_VAL; reset marks all partitions pending and a partition power-up re-marks it.
module lsq_ram_clear_seq
    import lsq_ram_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int INDEX     = 5,
    parameter int NUM_PARTS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PARTS-1:0] part_active,
    output logic                 clr_en,
    output logic [INDEX-1:0]     clr_addr,
    output logic                 busy,
    output logic                 ram_ready
);
    localparam int PLOG   = part_log(DEPTH, NUM_PARTS);
    localparam int PIDX_W = $clog2(NUM_PARTS);

    clr_state_t           state;
    logic [NUM_PARTS-1:0] pend_mask;
    logic [NUM_PARTS-1:0] part_prev;
    logic [NUM_PARTS-1:0] rise;
    logic [NUM_PARTS-1:0] done_bit;
    logic [NUM_PARTS-1:0] pend_next;
    logic [PLOG-1:0]      clr_ptr;
    logic [PIDX_W-1:0]    cur_part;
    logic                 last_entry;

    always_comb begin
        cur_part = '0;
        for (int i = NUM_PARTS - 1; i >= 0; i--) begin
            if (pend_mask[i]) cur_part = PIDX_W'(i);
        end
    end

    // A rise on the partition being cleared ORs back into its still-set bit, so its
    // pointer keeps running instead of restarting.
    assign busy       = (state == CLR_BUSY);
    assign last_entry = busy && (clr_ptr == '1);
    assign done_bit   = last_entry ? (NUM_PARTS'(1) << cur_part) : '0;
    assign rise       = part_active & ~part_prev;
    assign pend_next  = (pend_mask & ~done_bit) | rise;
    assign clr_en     = busy;
    assign clr_addr   = {cur_part, clr_ptr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLR_BUSY;
            pend_mask <= '1;
            clr_ptr   <= '0;
            part_prev <= '0;
            ram_ready <= 1'b0;
        end else begin
            pend_mask <= pend_next;
            part_prev <= part_active;
            state     <= (pend_next != '0) ? CLR_BUSY : CLR_IDLE;
            ram_ready <= (pend_next == '0);
            if (busy) clr_ptr <= last_entry ? '0 : clr_ptr + PLOG'(1);
        end
    end
endmodule

// File: rtl/lsq_ram_mp.sv
// Multi-port LSQ storage array with power-gated partitions, prioritised writes,
// optional write-to-read bypass and a hardware clearer driving ramReady_o.
module lsq_ram_mp
    import lsq_ram_pkg::*;
#(
    parameter int               RD_PORTS  = 2,
    parameter int               WR_PORTS  = 2,
    parameter int               DEPTH     = 32,
    parameter int               INDEX     = 5,
    parameter int               WIDTH     = 8,
    parameter int               NUM_PARTS = 4,
    parameter bit               BYPASS    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    lsq_ram_mp_if.slave  bus
);
    localparam int PLOG = part_log(DEPTH, NUM_PARTS);

    if (!params_ok(DEPTH, NUM_PARTS, INDEX)) begin : g_bad_params
        $error("lsq_ram_mp: illegal DEPTH/NUM_PARTS/INDEX combination");
    end

    logic [WIDTH-1:0]               ram [DEPTH];
    logic                           clr_en;
    logic [INDEX-1:0]               clr_addr;
    logic                           busy;
    logic                           ram_ready;
    logic [WR_PORTS-1:0]            wr_ok;
    logic [RD_PORTS-1:0][WIDTH-1:0] rd_data;

    function automatic logic part_on(input logic [INDEX-1:0] a, input logic [NUM_PARTS-1:0] act);
        return act[a[INDEX-1:PLOG]];
    endfunction

    lsq_ram_clear_seq #(
        .DEPTH     (DEPTH),
        .INDEX     (INDEX),
        .NUM_PARTS (NUM_PARTS)
    ) u_clear_seq (
        .clk         (clk),
        .reset_n     (reset_n),
        .part_active (bus.partActive_i),
        .clr_en      (clr_en),
        .clr_addr    (clr_addr),
        .busy        (busy),
        .ram_ready   (ram_ready)
    );

    always_comb begin
        for (int w = 0; w < WR_PORTS; w++) begin
            wr_ok[w] = bus.we_i[w] && !busy && part_on(bus.addrWr_i[w], bus.partActive_i);
        end
    end

    // Later ports overwrite earlier ones to the same entry, giving highest-index priority.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            ram[clr_addr] <= RESET_VAL;
        end else begin
            for (int w = 0; w < WR_PORTS; w++) begin
                if (wr_ok[w]) ram[bus.addrWr_i[w]] <= bus.dataWr_i[w];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < RD_PORTS; r++) begin
            rd_data[r] = part_on(bus.addr_i[r], bus.partActive_i) ? ram[bus.addr_i[r]] : RESET_VAL;
            if (BYPASS) begin
                for (int w = 0; w < WR_PORTS; w++) begin
                    if (wr_ok[w] && (bus.addrWr_i[w] == bus.addr_i[r])) rd_data[r] = bus.dataWr_i[w];
                end
            end
        end
    end

    assign bus.data_o     = rd_data;
    assign bus.ramReady_o = ram_ready;
endmodule

// File: tb/tb_lsq_ram_mp.sv
// Scoreboard bench for lsq_ram_mp (BYPASS=1): a behavioural model predicts read data and
// ramReady_o every cycle; a negedge monitor pops and compares.
module tb_lsq_ram_mp;
    logic clk;
    logic reset_n;

    lsq_ram_mp_if #(.RD_PORTS(2), .WR_PORTS(2), .INDEX(5), .WIDTH(8), .NUM_PARTS(4)) bus ();

    lsq_ram_mp #(
        .RD_PORTS(2), .WR_PORTS(2), .DEPTH(32), .INDEX(5), .WIDTH(8),
        .NUM_PARTS(4), .BYPASS(1'b1), .RESET_VAL(8'h00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0][7:0] d;
        logic [1:0]      chk;
        logic            rdy;
        int              cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: memory image, which entries hold a defined value, the set of
    // partitions still to be cleared, the position inside the one being cleared.
    logic [7:0] mem   [32];
    bit         known [32];
    bit         pend  [4];
    bit         prev  [4];
    int         ptr;
    bit         m_ready;

    function automatic bit m_busy();
        return pend[0] || pend[1] || pend[2] || pend[3];
    endfunction

    function automatic int lowest_pend();
        for (int p = 0; p < 4; p++) if (pend[p]) return p;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) known[i] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            pend[p] = 1'b1;
            prev[p] = 1'b0;
        end
        ptr     = 0;
        m_ready = 1'b0;
    endtask

    task automatic model_step();
        int cp;
        int a;
        if (m_busy()) begin
            cp = lowest_pend();
            mem[cp * 8 + ptr]   = 8'h00;
            known[cp * 8 + ptr] = 1'b1;
            if (ptr == 7) begin
                pend[cp] = 1'b0;
                ptr      = 0;
            end else begin
                ptr++;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                a = int'(bus.addrWr_i[w]);
                if (bus.we_i[w] && bus.partActive_i[a / 8]) begin
                    mem[a]   = bus.dataWr_i[w];
                    known[a] = 1'b1;
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (bus.partActive_i[p] && !prev[p]) pend[p] = 1'b1;
            prev[p] = bus.partActive_i[p];
        end
        m_ready = !m_busy();
    endtask

    task automatic drive(input logic [3:0] act, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [1:0] we, input logic [4:0] w0, input logic [4:0] w1,
                         input logic [7:0] d0, input logic [7:0] d1);
        exp_t e;
        int   a;
        int   wa;
        bus.partActive_i = act;
        bus.addr_i[0]    = a0;
        bus.addr_i[1]    = a1;
        bus.we_i         = we;
        bus.addrWr_i[0]  = w0;
        bus.addrWr_i[1]  = w1;
        bus.dataWr_i[0]  = d0;
        bus.dataWr_i[1]  = d1;
        e.rdy = m_ready;
        e.cyc = cyc;
        for (int r = 0; r < 2; r++) begin
            a = (r == 0) ? int'(a0) : int'(a1);
            if (!act[a / 8]) begin
                e.d[r]   = 8'h00;
                e.chk[r] = 1'b1;
            end else begin
                e.d[r]   = mem[a];
                e.chk[r] = known[a];
                if (!m_busy()) begin
                    for (int w = 0; w < 2; w++) begin
                        wa = (w == 0) ? int'(w0) : int'(w1);
                        if (we[w] && act[wa / 8] && wa == a) begin
                            e.d[r]   = (w == 0) ? d0 : d1;
                            e.chk[r] = 1'b1;
                        end
                    end
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        cyc++;
        #1;
    endtask

    task automatic idle(input logic [3:0] act, input int n);
        for (int i = 0; i < n; i++) begin
            drive(act, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
            tick();
        end
    endtask

    task automatic pulse_reset(input logic [3:0] act);
        reset_n = 1'b0;
        model_reset();
        drive(act, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (bus.ramReady_o !== e.rdy) begin
                n_bad++;
                $display("FAIL ramReady cyc=%0d got=%b exp=%b", e.cyc, bus.ramReady_o, e.rdy);
            end
            for (int r = 0; r < 2; r++) begin
                if (e.chk[r]) begin
                    n_cmp++;
                    if (bus.data_o[r] !== e.d[r]) begin
                        n_bad++;
                        $display("FAIL data_o[%0d] cyc=%0d addr=%0d got=%h exp=%h",
                                 r, e.cyc, bus.addr_i[r], bus.data_o[r], e.d[r]);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] act;
        logic [4:0] w0, w1, a0, a1;
        logic [1:0] we;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        reset_n = 1'b0;
        model_reset();
        idle(4'hF, 2);
        reset_n = 1'b1;

        // Power-up clear, then sweep all entries.
        idle(4'hF, 34);
        for (int i = 0; i < 16; i++) begin
            drive(4'hF, 5'(2 * i), 5'(2 * i + 1), 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
            tick();
        end

        // Two ports to one address, plus a marker in partition 0.
        drive(4'hF, 5'd5, 5'd1, 2'b11, 5'd5, 5'd5, 8'hAA, 8'h55);
        tick();
        drive(4'hF, 5'd5, 5'd5, 2'b01, 5'd1, 5'd0, 8'h11, 8'h00);
        tick();

        // Partition 1 gating and re-activation.
        drive(4'hF, 5'd9, 5'd1, 2'b10, 5'd0, 5'd9, 8'h00, 8'h3C);
        tick();
        drive(4'hF, 5'd9, 5'd1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();
        drive(4'b1101, 5'd9, 5'd1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();
        drive(4'b1101, 5'd9, 5'd9, 2'b01, 5'd9, 5'd0, 8'h77, 8'h00);
        tick();
        drive(4'b1101, 5'd9, 5'd1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();
        idle(4'hF, 10);
        drive(4'hF, 5'd9, 5'd1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();

        // Partition 3 rises while partition 1 is mid-clear.
        idle(4'b0101, 2);
        idle(4'b0111, 4);
        idle(4'hF, 16);

        // Reset while ready (asynchronous drop), then reset again mid-clear.
        pulse_reset(4'hF);
        idle(4'hF, 4);
        pulse_reset(4'hF);

        // Write issued during the clear is dropped.
        drive(4'hF, 5'd2, 5'd2, 2'b01, 5'd2, 5'd0, 8'hFF, 8'h00);
        tick();
        idle(4'hF, 34);
        drive(4'hF, 5'd2, 5'd2, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();

        // Random traffic with occasional partition power toggles.
        act = 4'hF;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) act[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 59) == 0) act = 4'hF;
            w0 = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            w1 = 5'($urandom_range(0, 1) ? int'(w0) : $urandom_range(0, 31));
            we = 2'($urandom_range(0, 3));
            a0 = 5'($urandom_range(0, 1) ? int'(w0) : $urandom_range(0, 31));
            a1 = 5'($urandom_range(0, 1) ? int'(w1) : $urandom_range(0, 31));
            drive(act, a0, a1, we, w0, w1, 8'($urandom), 8'($urandom));
            tick();
        end
        idle(4'hF, 34);

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
